// File: rtl/xain_pkg.sv
// Shared types and constants for the Xain'd Sleena loader path.
package xain_pkg;

  localparam int          IOCTL_ADDR_W    = 25;
  localparam logic [15:0] IOCTL_ROM_INDEX = 16'd0;

  typedef enum logic [2:0] {
    FEED_IDLE,
    FEED_LOAD,
    FEED_EMIT,
    FEED_GAP,
    FEED_HOLD,
    FEED_DONE
  } ioctl_feed_state_t;

endpackage

// File: rtl/xain_word_fifo.sv
// Synchronous word FIFO with show-ahead read data; writes when full and reads when empty are dropped.
module xain_word_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (wr_en && !full) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (rd_en && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/xain_ioctl_feeder.sv
// Serialises buffered 32-bit words onto the byte-wide ioctl download bus; first strobe 2 cycles after a word
// handshake, one byte per WR_GAP+1 cycles, stalled by ioctl_wait. XAIN_IOCTL_LE_EN selects little-endian byte order.
module xain_ioctl_feeder
  import xain_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int WR_GAP     = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    dl_start,
  input  logic [15:0]             dl_index,
  input  logic                    dl_end,
  input  logic                    word_valid,
  input  logic [31:0]             word_data,
  output logic                    word_ready,
  input  logic                    ioctl_wait,
  output logic                    ioctl_download,
  output logic [15:0]             ioctl_index,
  output logic                    ioctl_wr,
  output logic [IOCTL_ADDR_W-1:0] ioctl_addr,
  output logic [7:0]              ioctl_data,
  output logic                    err
);

  ioctl_feed_state_t       state;
  ioctl_feed_state_t       issue_st;
  logic                    end_flag;
  logic [1:0]              byte_sel;
  logic [IOCTL_ADDR_W-1:0] addr_cnt;
  logic [3:0]              gap_cnt;
  logic [31:0]             fifo_dat;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    push;
  logic                    pop;
  logic                    eval;
  logic                    do_emit;
  logic [7:0]              next_byte;

  assign word_ready = ioctl_download && !fifo_full && !end_flag;
  assign push       = word_valid && word_ready;

  xain_word_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (push),
    .wr_data (word_data),
    .rd_en   (pop),
    .rd_data (fifo_dat),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Cycles in which the FSM decides what the next cycle does on the bus.
  assign eval = (state == FEED_LOAD) || (state == FEED_HOLD) ||
                (state == FEED_GAP && gap_cnt == 4'd0) ||
                (state == FEED_EMIT && WR_GAP == 0);

  always_comb begin
    issue_st = FEED_LOAD;
    if (!fifo_empty) issue_st = ioctl_wait ? FEED_HOLD : FEED_EMIT;
    else if (end_flag) issue_st = FEED_DONE;
  end

  assign do_emit = eval && (issue_st == FEED_EMIT);
  assign pop     = do_emit && (byte_sel == 2'd3);

`ifdef XAIN_IOCTL_LE_EN
  assign next_byte = fifo_dat[{byte_sel, 3'b000} +: 8];
`else
  assign next_byte = fifo_dat[{~byte_sel, 3'b000} +: 8];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= FEED_IDLE;
      end_flag       <= 1'b0;
      byte_sel       <= 2'd0;
      addr_cnt       <= '0;
      gap_cnt        <= 4'd0;
      ioctl_download <= 1'b0;
      ioctl_index    <= IOCTL_ROM_INDEX;
      ioctl_wr       <= 1'b0;
      ioctl_addr     <= '0;
      ioctl_data     <= 8'd0;
      err            <= 1'b0;
    end else begin
      ioctl_wr <= 1'b0;
      if (dl_start && ioctl_download) err <= 1'b1;
      if (word_valid && state == FEED_IDLE) err <= 1'b1;
      if (dl_end && ioctl_download) end_flag <= 1'b1;

      if (do_emit) begin
        ioctl_wr   <= 1'b1;
        ioctl_addr <= addr_cnt;
        ioctl_data <= next_byte;
        byte_sel   <= byte_sel + 2'd1;
        addr_cnt   <= addr_cnt + IOCTL_ADDR_W'(1);
        if (&addr_cnt) err <= 1'b1;
      end

      if (eval && issue_st == FEED_DONE) ioctl_download <= 1'b0;

      case (state)
        FEED_IDLE: begin
          if (dl_start) begin
            state          <= FEED_LOAD;
            ioctl_download <= 1'b1;
            ioctl_index    <= dl_index;
            addr_cnt       <= '0;
            byte_sel       <= 2'd0;
            end_flag       <= 1'b0;
          end
        end
        FEED_LOAD, FEED_HOLD: state <= issue_st;
        FEED_EMIT: begin
          if (WR_GAP == 0) begin
            state <= issue_st;
          end else begin
            state   <= FEED_GAP;
            gap_cnt <= 4'(WR_GAP - 1);
          end
        end
        FEED_GAP: begin
          if (gap_cnt == 4'd0) state <= issue_st;
          else gap_cnt <= gap_cnt - 4'd1;
        end
        FEED_DONE: state <= FEED_IDLE;
        default:   state <= FEED_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xain_ioctl_feeder.sv
// Directed bench for xain_ioctl_feeder with default parameters (FIFO_DEPTH=4, WR_GAP=2).
module tb_xain_ioctl_feeder;

  logic        clk = 1'b0;
  logic        reset;
  logic        dl_start;
  logic [15:0] dl_index;
  logic        dl_end;
  logic        word_valid;
  logic [31:0] word_data;
  logic        word_ready;
  logic        ioctl_wait;
  logic        ioctl_download;
  logic [15:0] ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_data;
  logic        err;

  xain_ioctl_feeder dut (
    .clk            (clk),
    .reset          (reset),
    .dl_start       (dl_start),
    .dl_index       (dl_index),
    .dl_end         (dl_end),
    .word_valid     (word_valid),
    .word_data      (word_data),
    .word_ready     (word_ready),
    .ioctl_wait     (ioctl_wait),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_data     (ioctl_data),
    .err            (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          mon_addr[$];
  logic [7:0]  mon_data[$];
  int          mon_cyc[$];
  logic [31:0] exp_words[$];
  int          fall_cnt = 0;
  int          fall_cyc = 0;
  logic        prev_dl = 1'b0;
  logic        ready_dropped = 1'b0;
  int          hs_cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  always @(negedge clk) begin
    if (ioctl_wr === 1'b1) begin
      mon_addr.push_back(int'(ioctl_addr));
      mon_data.push_back(ioctl_data);
      mon_cyc.push_back(cyc);
    end
    if (prev_dl && !ioctl_download) begin
      fall_cnt++;
      fall_cyc = cyc;
    end
    prev_dl = ioctl_download;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input logic [31:0] w, input int k);
    logic [31:0] s;
`ifdef XAIN_IOCTL_LE_EN
    s = w >> (8 * k);
`else
    s = w >> (8 * (3 - k));
`endif
    return s[7:0];
  endfunction

  task automatic clear_mon();
    mon_addr.delete();
    mon_data.delete();
    mon_cyc.delete();
    exp_words.delete();
  endtask

  task automatic start_dl(input logic [15:0] idx);
    dl_index = idx;
    dl_start = 1'b1;
    @(negedge clk);
    dl_start = 1'b0;
  endtask

  task automatic pulse_end();
    dl_end = 1'b1;
    @(negedge clk);
    dl_end = 1'b0;
  endtask

  // dl_end rides along only on the cycle the handshake actually happens.
  task automatic push_word(input logic [31:0] w, input logic last);
    int t;
    t = 0;
    exp_words.push_back(w);
    word_valid = 1'b1;
    word_data  = w;
    while (!word_ready && t < 300) begin
      ready_dropped = 1'b1;
      @(negedge clk);
      t++;
    end
    check("push_ready", 32'(word_ready), 1);
    hs_cyc = cyc;
    dl_end = last;
    @(negedge clk);
    word_valid = 1'b0;
    dl_end     = 1'b0;
  endtask

  task automatic wait_fall(input int n0);
    int t;
    t = 0;
    while (fall_cnt == n0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("download_fall", 32'(fall_cnt != n0), 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic verify_stream(input string tag);
    int n;
    check({tag, "_count"}, mon_data.size(), 4 * exp_words.size());
    n = (mon_data.size() < 4 * exp_words.size()) ? mon_data.size() : 4 * exp_words.size();
    for (int i = 0; i < n; i++) begin
      check({tag, "_addr"}, mon_addr[i], i);
      check({tag, "_data"}, 32'(mon_data[i]), 32'(exp_byte(exp_words[i / 4], i % 4)));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_download"}, 32'(ioctl_download), 0);
    check({tag, "_wr"},       32'(ioctl_wr), 0);
    check({tag, "_addr"},     32'(ioctl_addr), 0);
    check({tag, "_data"},     32'(ioctl_data), 0);
    check({tag, "_index"},    32'(ioctl_index), 0);
    check({tag, "_ready"},    32'(word_ready), 0);
    check({tag, "_err"},      32'(err), 0);
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0;
    int t;
    int n;
    reset      = 1'b1;
    dl_start   = 1'b0;
    dl_index   = 16'd0;
    dl_end     = 1'b0;
    word_valid = 1'b0;
    word_data  = 32'd0;
    ioctl_wait = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    reset = 1'b0;
    @(negedge clk);

    // Two words, separate dl_end: timing of strobes and download window.
    clear_mon();
    f0 = fall_cnt;
    start_dl(16'h0000);
    check("basic_download_up", 32'(ioctl_download), 1);
    push_word(32'h1122_3344, 1'b0);
    t = hs_cyc;
    push_word(32'h5566_7788, 1'b0);
    pulse_end();
    wait_fall(f0);
    verify_stream("basic");
    if (mon_cyc.size() == 8) begin
      check("basic_first_latency", mon_cyc[0] - t, 2);
      for (int i = 1; i < 8; i++) check("basic_spacing", mon_cyc[i] - mon_cyc[i-1], 3);
      check("basic_fall_after_last", fall_cyc - mon_cyc[7], 3);
    end

    // ioctl_wait raised in the first strobe cycle for 10 cycles.
    clear_mon();
    f0 = fall_cnt;
    start_dl(16'h0001);
    check("wait_index", 32'(ioctl_index), 32'h0001);
    push_word(32'hA0B1_C2D3, 1'b1);
    t = 0;
    while (!ioctl_wr && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("wait_sync", 32'(ioctl_wr), 1);
    ioctl_wait = 1'b1;
    repeat (10) @(negedge clk);
    ioctl_wait = 1'b0;
    wait_fall(f0);
    verify_stream("wait");
    if (mon_cyc.size() >= 2) check("wait_stall_gap", mon_cyc[1] - mon_cyc[0], 11);

    // Six back-to-back words into a 4-deep FIFO, dl_end on the last handshake.
    clear_mon();
    f0 = fall_cnt;
    ready_dropped = 1'b0;
    start_dl(16'h0002);
    for (int i = 0; i < 6; i++) begin
      push_word({8'(4*i+1), 8'(4*i+2), 8'(4*i+3), 8'(4*i+4)}, (i == 5));
    end
    wait_fall(f0);
    verify_stream("burst");
    check("burst_ready_dropped", 32'(ready_dropped), 1);
    if (mon_cyc.size() == 24) begin
      check("burst_span", mon_cyc[23] - mon_cyc[0], 69);
      check("burst_fall_after_last", fall_cyc - mon_cyc[23], 3);
    end

    // Reset after the second byte of a word.
    clear_mon();
    start_dl(16'h00A5);
    push_word(32'hDEAD_BEEF, 1'b0);
    n = 0;
    t = 0;
    while (n < 2 && t < 100) begin
      @(negedge clk);
      if (ioctl_wr) n++;
      t++;
    end
    check("midrst_two_bytes", n, 2);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    reset = 1'b0;
    repeat (12) @(negedge clk);
    check("midrst_no_trailing", mon_data.size(), 2);
    clear_mon();
    f0 = fall_cnt;
    start_dl(16'h0000);
    push_word(32'hCAFE_F00D, 1'b1);
    wait_fall(f0);
    verify_stream("restart");

    // word_valid while idle is an error and the word is dropped.
    reset_pulse();
    check("idle_err_clear", 32'(err), 0);
    word_valid = 1'b1;
    word_data  = 32'h9999_9999;
    @(negedge clk);
    word_valid = 1'b0;
    check("idle_word_err", 32'(err), 1);
    check("idle_word_ready", 32'(word_ready), 0);
    clear_mon();
    f0 = fall_cnt;
    start_dl(16'h0000);
    pulse_end();
    wait_fall(f0);
    check("idle_word_dropped", mon_data.size(), 0);

    // Second dl_start during a transfer.
    reset_pulse();
    check("dup_err_clear", 32'(err), 0);
    clear_mon();
    f0 = fall_cnt;
    start_dl(16'h0007);
    push_word(32'h1122_3344, 1'b0);
    start_dl(16'h00FF);
    check("dup_start_err", 32'(err), 1);
    check("dup_start_index", 32'(ioctl_index), 32'h0007);
    pulse_end();
    wait_fall(f0);
    verify_stream("dup");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
